// File: rtl/sym_pkg.sv
// Shared types and the mirrored-word construction rule for the symmetry pattern generator.
package sym_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int MAXW      = 64;

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  // Low half carries the seed; the high half is its mirror, with pairs 0..k-1 inverted.
  function automatic logic [MAXW-1:0] mirror_word(input logic [MAXW/2-1:0] s,
                                                  input int k, input int half);
    logic [MAXW-1:0]   w;
    logic [MAXW/2-1:0] t;
    w = '0;
    for (int j = 0; j < MAXW/2; j++) begin
      t = s >> j;
      if (j < half)
        w = w | (MAXW'(t[0]) << j) | (MAXW'(t[0] ^ (j < k)) << (2*half-1-j));
    end
    return w;
  endfunction
endpackage

// File: rtl/sym_word_builder.sv
// Combinational (seed, k) -> WIDTH-bit word with exactly k mismatched mirrored pairs.
module sym_word_builder
  import sym_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int HALF = WIDTH/2,
  localparam int CW   = $clog2(HALF+1)
) (
  input  logic [HALF-1:0]  seed,
  input  logic [CW-1:0]    k,
  output logic [WIDTH-1:0] word
);
  assign word = WIDTH'(mirror_word((MAXW/2)'(seed), int'(k), HALF));
endmodule

// File: rtl/symmetry_pattern_gen.sv
// Stimulus source for the symmetry detector: single words or full seed sweeps
// with a requested mismatch count, delivered over a valid/ready port.
module symmetry_pattern_gen
  import sym_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int HALF = WIDTH/2,
  localparam int CW   = $clog2(HALF+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [HALF-1:0]  seed,
  input  logic [CW-1:0]    target_mismatch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_mismatch,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int NSEEDS = 1 << HALF;

  state_t          state, state_nxt;
  logic [HALF-1:0] s_q;
  logic [CW-1:0]   k_q;
  logic            mode_q;
  logic [HALF:0]   cnt;
  logic            xfer, k_bad, last;
  logic [HALF-1:0] b_seed;
  logic [CW-1:0]   b_k;
  logic [WIDTH-1:0] b_word;

  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign xfer      = out_valid & out_ready;
  assign k_bad     = target_mismatch > CW'(HALF);
  assign last      = !mode_q || (cnt == (HALF+1)'(NSEEDS-1));

  // One builder serves both the initial load (from the ports) and the
  // sweep reload (next seed), so the reload lands on the transfer edge.
  sym_word_builder #(.WIDTH(WIDTH)) u_builder (
    .seed (b_seed),
    .k    (b_k),
    .word (b_word)
  );

  always_comb begin
    state_nxt = state;
    b_seed    = s_q + HALF'(1'b1);
    b_k       = k_q;
    case (state)
      IDLE: begin
        b_seed = seed;
        b_k    = target_mismatch;
        if (start && !k_bad) state_nxt = SEND;
      end
      SEND:    if (xfer && last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q          <= '0;
      k_q          <= '0;
      mode_q       <= 1'b0;
      cnt          <= '0;
      out_data     <= '0;
      out_mismatch <= '0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE && start) begin
        if (k_bad) err <= 1'b1;
        else begin
          s_q          <= seed;
          k_q          <= target_mismatch;
          mode_q       <= mode;
          cnt          <= '0;
          out_data     <= b_word;
          out_mismatch <= target_mismatch;
        end
      end else if (xfer) begin
        cnt <= cnt + (HALF+1)'(1);
        if (mode_q) begin
          s_q      <= b_seed;
          out_data <= b_word;
        end
      end
    end
  end
endmodule

// File: tb/tb_symmetry_pattern_gen.sv
// Randomized self-checking bench for symmetry_pattern_gen against an arithmetic reference model.
module tb_symmetry_pattern_gen;
  localparam int WIDTH = 8;
  localparam int HALF  = 4;
  localparam int CW    = 3;
  localparam int NS    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [HALF-1:0]  seed = '0;
  logic [CW-1:0]    target_mismatch = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_mismatch;
  logic             busy, done, err;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] got[$];

  symmetry_pattern_gen #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .target_mismatch(target_mismatch), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mismatch(out_mismatch), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // High half = bit-reversed seed, with its top k bits (pairs 0..k-1) inverted.
  function automatic logic [WIDTH-1:0] ref_word(input int s, input int k);
    int rev, flip;
    rev = 0;
    for (int j = 0; j < HALF; j++)
      if (((s >> j) & 1) != 0) rev += 1 << (HALF-1-j);
    flip = ((1 << k) - 1) << (HALF - k);
    return WIDTH'(((rev ^ flip) << HALF) | s);
  endfunction

  function automatic int pairs_off(input logic [WIDTH-1:0] w);
    int n;
    logic [WIDTH-1:0] a;
    n = 0;
    for (int j = 0; j < HALF; j++) begin
      a = (w >> j) ^ (w >> (WIDTH-1-j));
      if (a[0]) n++;
    end
    return n;
  endfunction

  task automatic do_run(input int sd, input int k, input int md, input int rnd,
                        input int stall_at, input int noise);
    int n, idx, stalls, cyc;
    logic [WIDTH-1:0] exp_w;
    n = (md != 0) ? NS : 1;
    idx = 0; stalls = 0; cyc = 0;
    got.delete();
    @(negedge clk);
    seed = HALF'(sd); target_mismatch = CW'(k); mode = md[0]; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      exp_w = ref_word((sd + idx) % NS, k);
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("data", out_data, exp_w);
      chk("mism", out_mismatch, k);
      chk("pairs", pairs_off(out_data), k);
      if (noise != 0) begin
        start = 1'($urandom_range(0, 1));
        seed = HALF'($urandom);
        target_mismatch = CW'($urandom);
        mode = 1'($urandom);
      end
      if (idx == stall_at && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else if (rnd != 0) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
      if (out_ready) begin
        got.push_back(out_data);
        idx++;
      end
      @(posedge clk);
    end
    #1 start = 1'b0;
    chk("run_len", idx, n);
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("fin_valid", out_valid, 0);
    chk("fin_err", err, 0);
    @(negedge clk);
    chk("done_drop", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_mism", out_mismatch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single words with fixed expectations
    do_run(11, 0, 0, 0, -1, 0);
    chk("t1_word", got[0], 8'hDB);
    do_run(11, 2, 0, 0, -1, 0);
    chk("t2_word_k2", got[0], 8'h1B);
    do_run(11, 4, 0, 0, -1, 0);
    chk("t2_word_k4", got[0], 8'h2B);

    // sweep with start/seed noise while busy
    do_run(14, 1, 1, 0, -1, 1);
    chk("t3_len", got.size(), 16);
    chk("t3_w0", got[0], 8'hFE);
    chk("t3_w1", got[1], 8'h7F);
    chk("t3_w2", got[2], 8'h80);

    // three-cycle stall in mid-sweep
    do_run(3, 2, 1, 0, 2, 0);

    // out-of-range k
    for (int kk = 5; kk <= 7; kk++) begin
      @(negedge clk);
      seed = 4'h6; target_mismatch = CW'(kk); mode = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_valid", out_valid, 0);
      chk("err_busy", busy, 0);
      chk("err_done", done, 0);
      @(posedge clk); #1;
      chk("err_drop", err, 0);
      chk("err_idle", busy, 0);
    end

    // asynchronous reset after the 5th sweep word
    @(negedge clk);
    seed = 4'h5; target_mismatch = 3'd3; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) cnt++;
    end
    chk("rst_wait", cnt, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_mism", out_mismatch, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    chk("arst_nodone", done, 0);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("arst_nodone2", done, 0);
    chk("arst_idle", busy, 0);
    do_run(5, 3, 1, 1, -1, 0);

    // randomized runs
    repeat (8) begin
      do_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
             1, -1, int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
